// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer FSM states and PPROT bit positions.
// Imported by apb_slave_regs and apb_reg_bank.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam int PPROT_PRIV_BIT   = 0;
    localparam int PPROT_SECURE_BIT = 1;
    localparam int PPROT_INSTR_BIT  = 2;

endpackage

// File: rtl/apb_reg_bank.sv
// Word register array with per-byte write strobes.
// Ports: clk, rst (async, active high), we_i, idx_i, strb_i, wdata_i
// in; regs_o (all registers, packed) out.
module apb_reg_bank
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8,
    parameter int IDXW       = $clog2(NUM_REGS),
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 we_i,
    input  logic [IDXW-1:0]                      idx_i,
    input  logic [STRB_WIDTH-1:0]                strb_i,
    input  logic [DATA_WIDTH-1:0]                wdata_i,
    output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_o
);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '0;
        end else if (we_i) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (strb_i[b]) begin
                    regs_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign regs_o = regs_q;

endmodule

// File: rtl/apb_slave_regs.sv
// APB completer with a bank of byte-strobed word registers.
// Ports: clk, rst (async, active high), APB PSEL/PENABLE/PWRITE/PADDR/
// PWDATA/PSTRB/PPROT in; PRDATA/PREADY/PSLVERR out; ctrl_out = reg 0.
// Optional: define APB_WAIT_STATES_EN to insert WAIT_CYCLES wait states.
module apb_slave_regs
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_CYCLES = 2,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [STRB_WIDTH-1:0] PSTRB,
    input  logic [2:0]            PPROT,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [DATA_WIDTH-1:0] ctrl_out
);

    localparam int IDXW = $clog2(NUM_REGS);

    apb_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] strb_q, strb_d;
    logic                  priv_q, priv_d;

    logic                  latch;
    logic                  in_access;
    logic                  ready;
    logic                  err;
    logic                  we;
    logic [IDXW-1:0]       idx;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;

    // Any non-idle state means a setup phase has been latched, so a
    // PSEL&PENABLE cycle now is a genuine access phase.
    assign in_access = (state_q != ST_IDLE) && PSEL && PENABLE;

`ifdef APB_WAIT_STATES_EN
    logic [3:0] cnt_q, cnt_d;

    assign ready = in_access && (cnt_q == 4'd0);

    always_comb begin
        cnt_d = cnt_q;
        if (latch) begin
            cnt_d = 4'(WAIT_CYCLES);
        end else if (in_access && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, PPROT[2:1]};
`else
    assign ready = in_access;

    logic unused_ok;
    assign unused_ok = &{1'b0, PPROT[2:1], 4'(WAIT_CYCLES)};
`endif

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // PENABLE without a setup phase is ignored here.
                if (PSEL && !PENABLE) begin
                    latch   = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP, ST_ACCESS: begin
                if (!PSEL) begin
                    state_d = ST_IDLE;
                end else if (!PENABLE) begin
                    latch   = 1'b1;
                    state_d = ST_SETUP;
                end else if (ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        priv_d  = priv_q;
        if (latch) begin
            addr_d  = PADDR;
            write_d = PWRITE;
            wdata_d = PWDATA;
            strb_d  = PSTRB;
            priv_d  = PPROT[PPROT_PRIV_BIT];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            priv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            priv_q  <= priv_d;
        end
    end

    assign idx = addr_q[IDXW+1:2];

    // Register 0 is the control register: writes need privilege.
    assign err = (addr_q[1:0] != 2'b00)
              || (addr_q >= ADDR_WIDTH'(NUM_REGS * 4))
              || (write_q && idx == '0 && !priv_q);

    assign we = ready && write_q && !err;

    apb_reg_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDXW       (IDXW),
        .STRB_WIDTH (STRB_WIDTH)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we),
        .idx_i   (idx),
        .strb_i  (strb_q),
        .wdata_i (wdata_q),
        .regs_o  (regs)
    );

    assign PREADY   = ready;
    assign PSLVERR  = ready && err;
    assign PRDATA   = (ready && !write_q && !err) ? regs[idx] : '0;
    assign ctrl_out = regs[0];

endmodule

// File: tb/tb_apb_slave_regs.sv
// Directed bench for apb_slave_regs.
// Covers data path, strobes, errors, protection, latency and reset.
module tb_apb_slave_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [31:0] ctrl_out;

    int tests = 0;
    int fails = 0;

`ifdef APB_WAIT_STATES_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    always #5 clk = ~clk;

    apb_slave_regs #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .NUM_REGS    (8),
        .WAIT_CYCLES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PSTRB    (PSTRB),
        .PPROT    (PPROT),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .ctrl_out (ctrl_out)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full transfer; lat = access cycles until PREADY (0 on timeout).
    task automatic xfer(input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        input logic [2:0] prot,
                        output logic [31:0] rdata, output logic err,
                        output int lat);
        @(posedge clk) #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr;
        PADDR = addr; PWDATA = data; PSTRB = strb; PPROT = prot;
        @(posedge clk) #1;
        PENABLE = 1'b1;
        // Only the latched setup copy may be used from here on.
        PWDATA = ~data; PSTRB = ~strb; PPROT = ~prot;
        lat = 1;
        @(negedge clk);
        while (!PREADY && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rdata = PRDATA;
        err = PSLVERR;
        if (!PREADY) lat = 0;
        @(posedge clk) #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin
        rst = 1'b1;
        PSEL = 0; PENABLE = 0; PWRITE = 0;
        PADDR = 0; PWDATA = 0; PSTRB = 0; PPROT = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pready", 32'(PREADY), 32'd0);
        check("rst_pslverr", 32'(PSLVERR), 32'd0);
        check("rst_prdata", PRDATA, 32'd0);
        check("rst_ctrl", ctrl_out, 32'd0);
        @(posedge clk) #1;
        rst = 1'b0;

        xfer(1, 32'h04, 32'hDEADBEEF, 4'hF, 3'b001, rd, er, lat);
        check("wr4_err", 32'(er), 32'd0);
        check("wr4_lat", 32'(lat), 32'(LAT));
        @(negedge clk);
        check("pready_one_cycle", 32'(PREADY), 32'd0);
        check("prdata_idle", PRDATA, 32'd0);
        xfer(0, 32'h04, 32'h0, 4'h0, 3'b000, rd, er, lat);
        check("rd4_data", rd, 32'hDEADBEEF);
        check("rd4_err", 32'(er), 32'd0);
        check("rd4_lat", 32'(lat), 32'(LAT));

        xfer(1, 32'h08, 32'h11223344, 4'h5, 3'b001, rd, er, lat);
        xfer(0, 32'h08, 32'h0, 4'h0, 3'b000, rd, er, lat);
        check("strb5_data", rd, 32'h00220044);

        xfer(1, 32'h04, 32'h12345678, 4'h0, 3'b001, rd, er, lat);
        check("strb0_err", 32'(er), 32'd0);
        xfer(0, 32'h04, 32'h0, 4'h0, 3'b000, rd, er, lat);
        check("strb0_keep", rd, 32'hDEADBEEF);

        xfer(0, 32'h22, 32'h0, 4'h0, 3'b000, rd, er, lat);
        check("mis_lat", 32'(lat), 32'(LAT));
        check("mis_err", 32'(er), 32'd1);
        check("mis_data", rd, 32'd0);
        xfer(0, 32'h40, 32'h0, 4'h0, 3'b000, rd, er, lat);
        check("oor_err", 32'(er), 32'd1);
        check("oor_data", rd, 32'd0);

        xfer(1, 32'h1C, 32'hCAFEF00D, 4'hF, 3'b000, rd, er, lat);
        xfer(0, 32'h1C, 32'h0, 4'h0, 3'b000, rd, er, lat);
        check("last_reg", rd, 32'hCAFEF00D);

        xfer(1, 32'h00, 32'h000000FF, 4'hF, 3'b000, rd, er, lat);
        check("unpriv_err", 32'(er), 32'd1);
        check("unpriv_ctrl", ctrl_out, 32'd0);
        xfer(1, 32'h00, 32'h000000FF, 4'hF, 3'b001, rd, er, lat);
        check("priv_err", 32'(er), 32'd0);
        check("priv_ctrl", ctrl_out, 32'h000000FF);

        // PENABLE without a setup phase.
        @(posedge clk) #1;
        PSEL = 1; PENABLE = 1; PWRITE = 1;
        PADDR = 32'h0C; PWDATA = 32'hAAAA5555; PSTRB = 4'hF; PPROT = 1;
        @(negedge clk);
        check("viol_pready0", 32'(PREADY), 32'd0);
        @(negedge clk);
        check("viol_pready1", 32'(PREADY), 32'd0);
        @(posedge clk) #1;
        PSEL = 0; PENABLE = 0;
        xfer(0, 32'h0C, 32'h0, 4'h0, 3'b000, rd, er, lat);
        check("viol_nowrite", rd, 32'd0);

        // PSEL dropped after setup: transfer abandoned.
        @(posedge clk) #1;
        PSEL = 1; PENABLE = 0; PWRITE = 1;
        PADDR = 32'h10; PWDATA = 32'h01020304; PSTRB = 4'hF; PPROT = 1;
        @(posedge clk) #1;
        PSEL = 0; PENABLE = 1;
        @(negedge clk);
        check("abort_pready", 32'(PREADY), 32'd0);
        @(posedge clk) #1;
        PENABLE = 0;
        xfer(0, 32'h10, 32'h0, 4'h0, 3'b000, rd, er, lat);
        check("abort_nowrite", rd, 32'd0);

        // Reset in the middle of a write access.
        @(posedge clk) #1;
        PSEL = 1; PENABLE = 0; PWRITE = 1;
        PADDR = 32'h18; PWDATA = 32'h00000055; PSTRB = 4'hF; PPROT = 1;
        @(posedge clk) #1;
        PENABLE = 1;
`ifdef APB_WAIT_STATES_EN
        @(posedge clk) #1;
`endif
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstmid_pready", 32'(PREADY), 32'd0);
        check("rstmid_ctrl", ctrl_out, 32'd0);
        @(posedge clk) #1;
        PSEL = 0; PENABLE = 0;
        rst = 1'b0;
        xfer(0, 32'h18, 32'h0, 4'h0, 3'b000, rd, er, lat);
        check("rstmid_nowrite", rd, 32'd0);
        check("rstmid_idle_lat", 32'(lat), 32'(LAT));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
